// File: rtl/rx_char_assembler.sv
// rx_char_assembler
//
// Serial-to-parallel character stage for the receive path. It takes one
// mid-bit sampled line value per bit_strobe and frames it as start, data
// (LSB first), optional even parity, and stop. The finished character is
// presented through a single-entry valid/ready output buffer.
//
// Parameters:
//   DATA_BITS  - data bits per character (5..8)
//   PARITY_EN  - 1 = one even-parity bit expected between data and stop
//   BREAK_WAIT - 1 = after a framing error, wait for a sampled 1 before
//                accepting a new start bit
//
// Ports:
//   clk        - system clock, all logic on the rising edge
//   rst        - synchronous reset, active-high
//   bit_in     - sampled line value, qualified by bit_strobe
//   bit_strobe - one-cycle pulse per sampled bit
//   char_out   - assembled character, valid while char_valid=1
//   char_valid - output buffer holds a character
//   char_ready - consumer takes char_out this cycle when char_valid=1
//   frame_err  - stop bit sampled 0 for the buffered character
//   parity_err - parity mismatch for the buffered character
//   overrun    - one-cycle pulse: completed character dropped, buffer full
//   busy       - receiver is in any state other than IDLE

module rx_char_assembler #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int BREAK_WAIT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_in,
    input  logic                 bit_strobe,
    output logic [DATA_BITS-1:0] char_out,
    output logic                 char_valid,
    input  logic                 char_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DATA   = 3'd1;
    localparam logic [2:0] ST_PARITY = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
    localparam logic [2:0] ST_BREAK  = 3'd4;

    logic [2:0]           state;
    logic [CW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_mis;

    logic complete;
    logic new_fe;
    logic new_pe;
    logic pop;

    // A character completes on the strobe that samples the stop bit,
    // regardless of whether that stop bit is good.
    always_comb begin
        complete = bit_strobe && (state == ST_STOP);
        new_fe   = ~bit_in;
        new_pe   = (PARITY_EN != 0) ? par_mis : 1'b0;
        pop      = char_valid && char_ready;
    end

    assign busy = (state != ST_IDLE);

    // Framing state machine; advances only on bit strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par_mis <= 1'b0;
        end else if (bit_strobe) begin
            case (state)
                ST_IDLE: begin
                    if (!bit_in) begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                        par_mis <= 1'b0;
                    end
                end
                ST_DATA: begin
                    // Right shift: the first data bit received ends in bit 0.
                    shreg   <= {bit_in, shreg[DATA_BITS-1:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    par_mis <= bit_in ^ (^shreg);
                    state   <= ST_STOP;
                end
                ST_STOP: begin
                    if (!bit_in && (BREAK_WAIT != 0)) begin
                        state <= ST_BREAK;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_BREAK: begin
                    if (bit_in) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Single-entry output buffer. A completion landing in the same cycle
    // as a pop replaces the buffered character instead of emptying it.
    always_ff @(posedge clk) begin
        if (rst) begin
            char_out   <= '0;
            char_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (complete) begin
                if (!char_valid || char_ready) begin
                    char_out   <= shreg;
                    char_valid <= 1'b1;
                    frame_err  <= new_fe;
                    parity_err <= new_pe;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (pop) begin
                char_valid <= 1'b0;
                frame_err  <= 1'b0;
                parity_err <= 1'b0;
            end
        end
    end

endmodule

// File: doc/rx_char_assembler.md
Name: rx_char_assembler

Overview:
Serial-to-parallel character stage sitting directly downstream of the bit sample counter in the receive path. It consumes one mid-bit sampled line value per strobe, frames it as start / data (LSB first) / optional parity / stop, and presents the assembled character through a single-entry valid/ready output buffer. It flags framing errors, parity errors and overruns for the consuming control logic.

Parameters:
DATA_BITS, 8, number of data bits per character (5..8)
PARITY_EN, 0, 1 = one even-parity bit expected between data and stop
BREAK_WAIT, 1, 1 = after framing error, wait for a sampled 1 before accepting a new start bit

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
bit_in  input  1  sampled line value, qualified by bit_strobe
bit_strobe  input  1  one-cycle pulse per sampled bit from the sample counter
char_out  output  DATA_BITS  assembled character, valid while char_valid=1
char_valid  output  1  output buffer holds a character
char_ready  input  1  consumer accepts char_out this cycle when char_valid=1
frame_err  output  1  stop bit sampled 0 for the buffered character (qualified by char_valid)
parity_err  output  1  parity mismatch for the buffered character (qualified by char_valid; 0 when PARITY_EN=0)
overrun  output  1  one-cycle pulse: completed character dropped because buffer was full
busy  output  1  1 in any state other than IDLE

Behaviour:
- Reset: one clock, synchronous, active-high. rst=1 at a rising edge forces state=IDLE, bit counter=0, shift register=0, char_out=0, char_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0. rst overrides every other input, including in mid-frame and while the buffer is full; any buffered or partial character is discarded.
- All state changes occur only on cycles with bit_strobe=1, except buffer handshake and the overrun pulse.
- FSM states: IDLE, DATA, PARITY, STOP, BREAK.
  - IDLE: strobe with bit_in=0 -> DATA, bit count=0. Strobe with bit_in=1 -> stay.
  - DATA: each strobe right-shifts bit_in into the MSB of the shift register (first received bit ends in bit 0) and increments the count. On the strobe that receives bit DATA_BITS-1 -> PARITY if PARITY_EN=1, else STOP.
  - PARITY: strobe: record mismatch = bit_in XOR (XOR of data bits) (even parity) -> STOP.
  - STOP: strobe: the character completes. If bit_in=1 -> IDLE with frame_err_n=0. If bit_in=0 -> frame_err_n=1, then BREAK if BREAK_WAIT=1, else IDLE.
  - BREAK: strobe with bit_in=1 -> IDLE. Strobe with bit_in=0 -> stay, and nothing is delivered.
- Completion latency: char_valid, char_out, frame_err and parity_err update on the rising edge that samples the STOP strobe, so they are visible the cycle after the strobe.
- Output buffer (single entry):
  - Pop: char_valid=1 and char_ready=1 at an edge clears char_valid, unless a completion happens in the same cycle.
  - Completion with the buffer empty, or a pop in the same cycle: the new character and its flags load and char_valid=1.
  - Completion with char_valid=1 and char_ready=0: the new character is discarded, the buffer keeps the old character and flags unchanged, and overrun=1 for exactly one cycle.
  - char_ready is ignored while char_valid=0.
- frame_err and parity_err travel with the buffered character. They clear on pop and are meaningful only while char_valid=1.
- The shift register and bit counter are DATA_BITS and clog2(DATA_BITS+1) wide. The counter never wraps, because the DATA exit happens at DATA_BITS-1.
- bit_strobe on consecutive cycles is legal. Each pulse is one bit.

Test Plan:
- Frame 0,1,0,1,0,1,0,1,0,1 (start, 0x55 LSB first, stop) with char_ready=1 -> char_valid pulses high one cycle after the stop strobe, char_out=0x55, frame_err=0, overrun=0.
- Frame for 0xA5 with stop bit 0 and BREAK_WAIT=1, then three strobes of 0, then strobes of 1 and then a 0x3C frame -> the first character is delivered with char_out=0xA5 and frame_err=1. The zeros after the error produce nothing and busy=1 throughout. The 0x3C frame is received correctly after the line returns to 1.
- char_ready=0: send 0x11 then 0x22 -> char_out stays 0x11, overrun=1 for one cycle after the second stop strobe. Then char_ready=1 -> char_valid=0 on the next edge.
- char_valid=1 (0x11) with char_ready=1 in the exact cycle that 0x22 completes -> no overrun, char_valid stays 1, char_out=0x22.
- PARITY_EN=1: send 0x07 with parity bit 1, then 0x07 with parity bit 0 -> parity_err=0 for the first and 1 for the second, char_out=0x07 both times.
- rst=1 for one cycle after the 4th data bit of a frame, then a clean 0x5A frame -> all outputs 0 after the reset edge, no spurious character, and char_out=0x5A next.
